// File: rtl/spi_slave_if.sv
// Bus bundle for the SPI slave: the serial pins plus the transmit/receive
// word-level handshake seen by the host logic.
interface spi_slave_if;
    // SPI pins
    logic        spi_clk_i;
    logic        spi_ss_n_i;
    logic        spi_mosi_i;
    logic        spi_miso_o;
    logic        spi_miso_oe_o;
    // Transmit side
    logic [31:0] tx_data_i;
    logic [2:0]  tx_bytes_valid_i;
    logic        tx_load_i;
    logic        tx_ready_o;
    // Receive side
    logic        rx_clear_i;
    logic [31:0] rx_data_o;
    logic [2:0]  rx_bytes_valid_o;
    logic        rx_done_o;
    logic        overrun_o;

    // Seen from the slave block itself
    modport slave (
        input  spi_clk_i,
        input  spi_ss_n_i,
        input  spi_mosi_i,
        output spi_miso_o,
        output spi_miso_oe_o,
        input  tx_data_i,
        input  tx_bytes_valid_i,
        input  tx_load_i,
        output tx_ready_o,
        input  rx_clear_i,
        output rx_data_o,
        output rx_bytes_valid_o,
        output rx_done_o,
        output overrun_o
    );

    // Seen from the SPI master / host driving the block
    modport master (
        output spi_clk_i,
        output spi_ss_n_i,
        output spi_mosi_i,
        input  spi_miso_o,
        input  spi_miso_oe_o,
        output tx_data_i,
        output tx_bytes_valid_i,
        output tx_load_i,
        input  tx_ready_o,
        output rx_clear_i,
        input  rx_data_o,
        input  rx_bytes_valid_o,
        input  rx_done_o,
        input  overrun_o
    );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, oversampled by clk_i.
// All SPI pins are brought into the clk_i domain through two-flop
// synchronisers; edges of SCLK and SS_N are detected on the synchronised
// copies. Transmit data is a word of up to four bytes loaded while idle;
// received bytes accumulate into a 32-bit word, newest byte lowest.
module spi_slave #(
    parameter logic MISO_IDLE = 1'b0
) (
    input logic       clk_i,
    input logic       rstn_i,
    spi_slave_if.slave bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state_reg, state_next;

    // ------------------------------------------------------------------
    // Input synchronisers: index 0 = SCLK, 1 = SS_N, 2 = MOSI
    // ------------------------------------------------------------------
    logic [2:0] sync_in;
    logic [2:0] sync1_reg;
    logic [2:0] sync2_reg;

    assign sync_in = {bus.spi_mosi_i, bus.spi_ss_n_i, bus.spi_clk_i};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            // Two-stage synchroniser for one asynchronous SPI pin
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    sync1_reg[gi] <= 1'b0;
                    sync2_reg[gi] <= 1'b0;
                end else begin
                    sync1_reg[gi] <= sync_in[gi];
                    sync2_reg[gi] <= sync1_reg[gi];
                end
            end
        end
    endgenerate

    logic sclk_s, ss_n_s, mosi_s;
    assign sclk_s = sync2_reg[0];
    assign ss_n_s = sync2_reg[1];
    assign mosi_s = sync2_reg[2];

    logic sclk_prev_reg, ss_prev_reg;

    // Previous synchronised SCLK / SS_N for edge detection
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sclk_prev_reg <= 1'b0;
            ss_prev_reg   <= 1'b0;
        end else begin
            sclk_prev_reg <= sclk_s;
            ss_prev_reg   <= ss_n_s;
        end
    end

    logic sclk_rise, sclk_fall, ss_fall, ss_rise;
    assign sclk_rise = sclk_s & ~sclk_prev_reg;
    assign sclk_fall = ~sclk_s & sclk_prev_reg;
    assign ss_fall   = ~ss_n_s & ss_prev_reg;
    assign ss_rise   = ss_n_s & ~ss_prev_reg;

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    logic frame_start, frame_end;

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and frame boundary strobes
    always_comb begin
        state_next  = state_reg;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ss_fall) begin
                    state_next  = ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_next = IDLE;
                    frame_end  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------
    logic        load_ok;
    logic [2:0]  load_bytes;
    logic [31:0] tx_word_reg;
    logic [2:0]  tx_bytes_reg;
    logic [31:0] start_word;
    logic [2:0]  start_bytes;

    assign load_ok    = bus.tx_load_i && (state_reg == IDLE);
    assign load_bytes = (bus.tx_bytes_valid_i > 3'd4) ? 3'd4 : bus.tx_bytes_valid_i;

    // A load arriving in the very cycle the frame opens still feeds that frame
    assign start_word  = load_ok ? bus.tx_data_i : tx_word_reg;
    assign start_bytes = load_ok ? load_bytes    : tx_bytes_reg;

    // Stored transmit word: written while idle, consumed when a frame ends
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tx_word_reg  <= 32'd0;
            tx_bytes_reg <= 3'd0;
        end else if (frame_end) begin
            tx_word_reg  <= 32'd0;
            tx_bytes_reg <= 3'd0;
        end else if (load_ok) begin
            tx_word_reg  <= bus.tx_data_i;
            tx_bytes_reg <= load_bytes;
        end
    end

    logic [31:0] tx_shift_reg;
    logic [5:0]  tx_bits_reg;
    logic        miso_reg;

    // MISO shifter: bit 31 appears on frame entry, then one bit per SCLK fall
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tx_shift_reg <= 32'd0;
            tx_bits_reg  <= 6'd0;
            miso_reg     <= MISO_IDLE;
        end else if (frame_start) begin
            tx_shift_reg <= start_word;
            tx_bits_reg  <= {start_bytes, 3'b000};
            miso_reg     <= (start_bytes != 3'd0) ? start_word[31] : MISO_IDLE;
        end else if (state_reg == IDLE || frame_end) begin
            tx_bits_reg <= 6'd0;
            miso_reg    <= MISO_IDLE;
        end else if (sclk_fall) begin
            if (tx_bits_reg > 6'd1) begin
                tx_shift_reg <= {tx_shift_reg[30:0], 1'b0};
                tx_bits_reg  <= tx_bits_reg - 6'd1;
                miso_reg     <= tx_shift_reg[30];
            end else begin
                tx_bits_reg <= 6'd0;
                miso_reg    <= MISO_IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    // Only the seven older bits need storing; the eighth is taken live
    // from the synchroniser when the byte completes.
    logic [6:0]  rx_shift_reg;
    logic [2:0]  rx_cnt_reg;
    logic        byte_done;
    logic [7:0]  new_byte;

    assign byte_done = (state_reg == ACTIVE) && !ss_rise && sclk_rise && (rx_cnt_reg == 3'd7);
    assign new_byte  = {rx_shift_reg, mosi_s};

    // Bit shifter; a partial byte is discarded whenever the frame is not active
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_shift_reg <= 7'd0;
            rx_cnt_reg   <= 3'd0;
        end else if (state_reg != ACTIVE || ss_rise) begin
            rx_shift_reg <= 7'd0;
            rx_cnt_reg   <= 3'd0;
        end else if (sclk_rise) begin
            rx_shift_reg <= {rx_shift_reg[5:0], mosi_s};
            rx_cnt_reg   <= rx_cnt_reg + 3'd1;
        end
    end

    logic [31:0] rx_data_reg;
    logic [2:0]  rx_bytes_reg;
    logic        overrun_reg;

    // Received word; a clear in the same cycle as a completed byte keeps that byte
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_data_reg  <= 32'd0;
            rx_bytes_reg <= 3'd0;
            overrun_reg  <= 1'b0;
        end else if (bus.rx_clear_i) begin
            overrun_reg <= 1'b0;
            if (byte_done) begin
                rx_data_reg  <= {24'd0, new_byte};
                rx_bytes_reg <= 3'd1;
            end else begin
                rx_data_reg  <= 32'd0;
                rx_bytes_reg <= 3'd0;
            end
        end else if (byte_done) begin
            if (rx_bytes_reg == 3'd4) begin
                overrun_reg <= 1'b1;
            end else begin
                rx_data_reg  <= {rx_data_reg[23:0], new_byte};
                rx_bytes_reg <= rx_bytes_reg + 3'd1;
            end
        end
    end

    logic rx_done_reg;

    // One-cycle frame-end pulse, coincides with the first idle cycle
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_done_reg <= 1'b0;
        end else begin
            rx_done_reg <= frame_end;
        end
    end

    assign bus.spi_miso_o       = miso_reg;
    assign bus.spi_miso_oe_o    = (state_reg == ACTIVE);
    assign bus.tx_ready_o       = (state_reg == IDLE);
    assign bus.rx_data_o        = rx_data_reg;
    assign bus.rx_bytes_valid_o = rx_bytes_reg;
    assign bus.rx_done_o        = rx_done_reg;
    assign bus.overrun_o        = overrun_reg;

endmodule

// File: tb/tb_spi_slave.sv
// Testbench for spi_slave: directed vector table, hand-written corner
// sequences and randomized frames checked against a byte-queue model.
module tb_spi_slave;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    spi_slave_if bus();

    spi_slave #(.MISO_IDLE(1'b0)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // rx_done monitoring, sampled away from the active edge
    int done_cycles  = 0;
    int done_notrdy  = 0;
    always @(negedge clk) begin
        if (bus.rx_done_o === 1'b1) begin
            done_cycles++;
            if (bus.tx_ready_o !== 1'b1) done_notrdy++;
        end
    end

    // Reference model state
    logic [31:0] m_txw;
    int          m_txn;
    logic [7:0]  m_q[$];
    logic        m_ovr;

    int oe_bad;
    int ready_bad;

    typedef struct {
        logic        clr;
        logic        load;
        logic [31:0] txw;
        logic [2:0]  txn;
        logic        mid;
        int          nbits;
        logic [39:0] mosi;
        logic [31:0] exp_data;
        logic [2:0]  exp_n;
        logic        exp_ovr;
        logic [39:0] exp_miso;
    } vec_t;

    vec_t vt[8];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovr = 1'b0;
        m_txw = 32'd0;
        m_txn = 0;
    endtask

    task automatic model_push(input logic [7:0] b);
        if (m_q.size() == 4) m_ovr = 1'b1;
        else m_q.push_back(b);
    endtask

    function automatic logic [31:0] model_data();
        logic [31:0] d = 32'd0;
        for (int i = 0; i < m_q.size(); i++)
            d = d | ({24'd0, m_q[i]} << (8 * (m_q.size() - 1 - i)));
        return d;
    endfunction

    function automatic logic [39:0] exp_miso(input int nbits);
        logic [39:0] v = 40'd0;
        for (int i = 0; i < nbits; i++)
            v[39-i] = (i < 8 * m_txn) ? m_txw[31-i] : 1'b0;
        return v;
    endfunction

    task automatic pulse_load(input logic [31:0] w, input logic [2:0] n);
        bus.tx_data_i        = w;
        bus.tx_bytes_valid_i = n;
        bus.tx_load_i        = 1'b1;
        tick(1);
        bus.tx_load_i        = 1'b0;
    endtask

    // Load made while idle: the model takes it
    task automatic do_load(input logic [31:0] w, input logic [2:0] n);
        pulse_load(w, n);
        m_txw = w;
        m_txn = (n > 3'd4) ? 4 : int'(n);
    endtask

    task automatic do_clear();
        bus.rx_clear_i = 1'b1;
        tick(1);
        bus.rx_clear_i = 1'b0;
        m_q.delete();
        m_ovr = 1'b0;
    endtask

    // One SCLK period: MISO is captured just before the rising edge
    task automatic send_bit(input logic b, output logic m);
        bus.spi_mosi_i = b;
        tick(4);
        m = bus.spi_miso_o;
        if (bus.spi_miso_oe_o !== 1'b1) oe_bad++;
        if (bus.tx_ready_o !== 1'b0) ready_bad++;
        bus.spi_clk_i = 1'b1;
        tick(8);
        bus.spi_clk_i = 1'b0;
        tick(4);
    endtask

    task automatic run_frame(input int nbits, input logic [39:0] mosi, input bit mid,
                             output logic [39:0] cap);
        int d0;
        logic m;
        d0        = done_cycles;
        oe_bad    = 0;
        ready_bad = 0;
        cap       = 40'd0;
        bus.spi_ss_n_i = 1'b0;
        tick(8);
        for (int i = 0; i < nbits; i++) begin
            send_bit(mosi[39-i], m);
            cap[39-i] = m;
            if (mid && i == 2) pulse_load(32'hFFFF_FFFF, 3'd4);
        end
        tick(4);
        bus.spi_ss_n_i = 1'b1;
        tick(8);
        check("rx_done_cycles", 40'(done_cycles - d0), 40'd1);
        check("oe_in_frame", 40'(oe_bad), 40'd0);
        check("tx_ready_in_frame", 40'(ready_bad), 40'd0);
        check("oe_after_frame", {39'd0, bus.spi_miso_oe_o}, 40'd0);
        for (int b = 0; b < nbits / 8; b++) begin
            logic [39:0] t;
            t = mosi;
            model_push(t[39-8*b -: 8]);
        end
        m_txn = 0;
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, "_miso"},  {39'd0, bus.spi_miso_o}, 40'd0);
        check({tag, "_oe"},    {39'd0, bus.spi_miso_oe_o}, 40'd0);
        check({tag, "_ready"}, {39'd0, bus.tx_ready_o}, 40'd1);
        check({tag, "_rxdata"}, {8'd0, bus.rx_data_o}, 40'd0);
        check({tag, "_rxn"},   {37'd0, bus.rx_bytes_valid_o}, 40'd0);
        check({tag, "_done"},  {39'd0, bus.rx_done_o}, 40'd0);
        check({tag, "_ovr"},   {39'd0, bus.overrun_o}, 40'd0);
    endtask

    initial begin
        logic [39:0] cap;
        logic [39:0] em;
        logic [63:0] rnd;
        logic m;
        int nb;
        int d0;

        bus.spi_clk_i        = 1'b0;
        bus.spi_ss_n_i       = 1'b1;
        bus.spi_mosi_i       = 1'b0;
        bus.tx_data_i        = 32'd0;
        bus.tx_bytes_valid_i = 3'd0;
        bus.tx_load_i        = 1'b0;
        bus.rx_clear_i       = 1'b0;
        model_reset();

        //          clr   load  txw            txn   mid   nb  mosi              data           n     ovr   miso
        vt[0] = '{1'b1, 1'b1, 32'hA5C3_0000, 3'd2, 1'b0, 16, 40'h1234_000000, 32'h0000_1234, 3'd2, 1'b0, 40'hA5C3_000000};
        vt[1] = '{1'b1, 1'b0, 32'h0,         3'd0, 1'b0, 40, 40'h0102030405,  32'h0102_0304, 3'd4, 1'b1, 40'h0};
        vt[2] = '{1'b1, 1'b1, 32'hDEAD_BEEF, 3'd7, 1'b0, 40, 40'hFF11223344,  32'hFF11_2233, 3'd4, 1'b1, 40'hDEADBEEF00};
        vt[3] = '{1'b1, 1'b0, 32'h0,         3'd0, 1'b0, 11, 40'hFFE0000000,  32'h0000_00FF, 3'd1, 1'b0, 40'h0};
        vt[4] = '{1'b0, 1'b0, 32'h0,         3'd0, 1'b0,  8, 40'h5A00000000,  32'h0000_FF5A, 3'd2, 1'b0, 40'h0};
        vt[5] = '{1'b1, 1'b1, 32'h3C00_0000, 3'd1, 1'b1, 16, 40'hABCD000000,  32'h0000_ABCD, 3'd2, 1'b0, 40'h3C00000000};
        vt[6] = '{1'b1, 1'b1, 32'h1234_5678, 3'd0, 1'b0,  8, 40'h8100000000,  32'h0000_0081, 3'd1, 1'b0, 40'h0};
        vt[7] = '{1'b0, 1'b1, 32'h8000_0001, 3'd3, 1'b0, 32, 40'h1122334400,  32'h8111_2233, 3'd4, 1'b1, 40'h8000000000};

        // Reset state
        tick(3);
        check_outputs_reset("in_reset");
        rstn = 1'b1;
        tick(4);
        check_outputs_reset("after_reset");

        // Directed vector table
        for (int v = 0; v < 8; v++) begin
            if (vt[v].clr) do_clear();
            if (vt[v].load) do_load(vt[v].txw, vt[v].txn);
            run_frame(vt[v].nbits, vt[v].mosi, vt[v].mid, cap);
            check($sformatf("vec%0d_miso", v), cap, vt[v].exp_miso);
            check($sformatf("vec%0d_rxdata", v), {8'd0, bus.rx_data_o}, {8'd0, vt[v].exp_data});
            check($sformatf("vec%0d_rxn", v), {37'd0, bus.rx_bytes_valid_o}, {37'd0, vt[v].exp_n});
            check($sformatf("vec%0d_ovr", v), {39'd0, bus.overrun_o}, {39'd0, vt[v].exp_ovr});
            $display("vec %0d: nbits=%0d miso=%h rx=%h n=%0d ovr=%0d", v, vt[v].nbits, cap,
                     bus.rx_data_o, bus.rx_bytes_valid_o, bus.overrun_o);
        end

        // Clear in the same cycle the fourth byte (0x7E) completes
        do_clear();
        bus.spi_ss_n_i = 1'b0;
        tick(8);
        for (int i = 0; i < 24; i++) begin
            logic [23:0] pre;
            pre = 24'h112233;
            send_bit(pre[23-i], m);
        end
        for (int i = 0; i < 7; i++) begin
            logic [7:0] b7e;
            b7e = 8'h7E;
            send_bit(b7e[7-i], m);
        end
        bus.spi_mosi_i = 1'b0;
        tick(4);
        bus.spi_clk_i = 1'b1;
        tick(2);
        bus.rx_clear_i = 1'b1;
        tick(1);
        bus.rx_clear_i = 1'b0;
        tick(5);
        bus.spi_clk_i = 1'b0;
        tick(4);
        bus.spi_ss_n_i = 1'b1;
        tick(8);
        check("clr_same_rxdata", {8'd0, bus.rx_data_o}, 40'h00_0000_007E);
        check("clr_same_rxn", {37'd0, bus.rx_bytes_valid_o}, 40'd1);
        check("clr_same_ovr", {39'd0, bus.overrun_o}, 40'd0);
        $display("clear-with-byte: rx=%h n=%0d", bus.rx_data_o, bus.rx_bytes_valid_o);
        m_q.delete();
        m_q.push_back(8'h7E);
        m_ovr = 1'b0;
        m_txn = 0;

        // Reset after 4 bits of a frame
        do_load(32'hCAFE_BABE, 3'd4);
        bus.spi_ss_n_i = 1'b0;
        tick(8);
        for (int i = 0; i < 4; i++) send_bit(1'b1, m);
        d0 = done_cycles;
        rstn = 1'b0;
        tick(1);
        bus.spi_ss_n_i = 1'b1;
        bus.spi_clk_i  = 1'b0;
        tick(2);
        check_outputs_reset("midframe_reset");
        rstn = 1'b1;
        tick(10);
        check("reset_no_done", 40'(done_cycles - d0), 40'd0);
        model_reset();
        em = exp_miso(8);
        run_frame(8, 40'hC300000000, 1'b0, cap);
        check("post_reset_miso", cap, em);
        check("post_reset_rxdata", {8'd0, bus.rx_data_o}, 40'h00_0000_00C3);
        check("post_reset_rxn", {37'd0, bus.rx_bytes_valid_o}, 40'd1);
        $display("post-reset frame: miso=%h rx=%h", cap, bus.rx_data_o);

        // Randomized frames against the model
        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 2) == 0) do_clear();
            if ($urandom_range(0, 1) == 1) do_load($urandom, 3'($urandom_range(0, 7)));
            nb  = $urandom_range(0, 40);
            rnd = {$urandom, $urandom};
            em  = exp_miso(nb);
            run_frame(nb, rnd[39:0], 1'b0, cap);
            check($sformatf("rnd%0d_miso", r), cap, em);
            check($sformatf("rnd%0d_rxdata", r), {8'd0, bus.rx_data_o}, {8'd0, model_data()});
            check($sformatf("rnd%0d_rxn", r), {37'd0, bus.rx_bytes_valid_o}, 40'(m_q.size()));
            check($sformatf("rnd%0d_ovr", r), {39'd0, bus.overrun_o}, {39'd0, m_ovr});
            $display("rnd %0d: nbits=%0d miso=%h rx=%h n=%0d ovr=%0d", r, nb, cap,
                     bus.rx_data_o, bus.rx_bytes_valid_o, bus.overrun_o);
        end

        check("done_with_ready", 40'(done_notrdy), 40'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter: MISO_IDLE, 1'b0, value driven on spi_miso_o when no transmit data remains or no frame is active.
REQ-002 SHALL have ports (clock and reset first):
- clk_i  in  1  system clock; the single clock of the block.
- rstn_i  in  1  reset; asynchronous, active-low.
- spi_clk_i  in  1  SPI serial clock from master; asynchronous to clk_i.
- spi_ss_n_i  in  1  slave select; active-low; asynchronous.
- spi_mosi_i  in  1  serial data from master.
- spi_miso_o  out  1  serial data to master.
- spi_miso_oe_o  out  1  MISO output enable; high only while a frame is active.
- tx_data_i  in  32  transmit word; byte [31:24] is sent first.
- tx_bytes_valid_i  in  3  number of valid transmit bytes, 0..4.
- tx_load_i  in  1  single-cycle load strobe for tx_data_i / tx_bytes_valid_i.
- tx_ready_o  out  1  high when a transmit load is accepted.
- rx_clear_i  in  1  clears receive word, fill level and overrun.
- rx_data_o  out  32  received bytes; newest byte in [7:0].
- rx_bytes_valid_o  out  3  received byte count, 0..4.
- rx_done_o  out  1  one-cycle pulse at frame end.
- overrun_o  out  1  sticky; a received byte was dropped.

Function
REQ-003 SHALL synchronise spi_clk_i, spi_ss_n_i and spi_mosi_i through two clk_i flip-flop stages each, and act only on the synchronised values.
REQ-004 SHALL implement SPI mode 0, MSB first: MOSI sampled on rising spi_clk_i; MISO changed on falling spi_clk_i.
REQ-005 SHALL operate correctly when the clk_i frequency is at least 8x the spi_clk_i frequency; behaviour below that ratio is undefined.
REQ-006 SHALL use a state machine with states IDLE and ACTIVE:
- IDLE -> ACTIVE on a synchronised falling edge of ss_n.
- ACTIVE -> IDLE on a synchronised rising edge of ss_n.
REQ-007 SHALL accept tx_load_i only when tx_ready_o=1; tx_ready_o SHALL be 1 in IDLE and 0 in ACTIVE.
- A tx_load_i with tx_ready_o=0 SHALL be ignored.
- tx_bytes_valid_i values >4 SHALL be treated as 4.
REQ-008 On entry to ACTIVE, spi_miso_o SHALL present bit 31 of the loaded word on the next clk_i cycle, before the first SCLK rising edge.
REQ-009 SHALL advance MISO one bit per synchronised falling SCLK edge, in the order [31]..[0].
- After 8*tx_bytes_valid bits, or when no word was loaded, MISO SHALL drive MISO_IDLE.
- The loaded word SHALL be consumed at frame end: the next frame sends MISO_IDLE unless a new load is made.
REQ-010 On each synchronised rising SCLK edge in ACTIVE, SHALL shift the synchronised MOSI into an 8-bit shift register with a 3-bit bit counter.
REQ-011 On the 8th bit, on the following clk_i edge:
- rx_data_o SHALL be updated to {rx_data_o[23:0], byte}.
- rx_bytes_valid_o SHALL increment.
REQ-012 If rx_bytes_valid_o=4 when a byte completes, the byte SHALL be dropped, rx_data_o and rx_bytes_valid_o SHALL hold, and overrun_o SHALL be set.
REQ-013 rx_clear_i SHALL set rx_data_o=0, rx_bytes_valid_o=0 and overrun_o=0 in the next cycle.
- If a byte completes in the same cycle, the result SHALL be rx_data_o={24'd0,byte} and rx_bytes_valid_o=1.
REQ-014 On ss_n deassertion mid-byte:
- The partial byte SHALL be discarded and the bit counter cleared.
- Received complete bytes SHALL be retained.
REQ-015 rx_done_o SHALL pulse high for exactly one cycle on the ACTIVE->IDLE transition; tx_ready_o SHALL be 1 in that same cycle.
REQ-016 SCLK edges while in IDLE SHALL be ignored.
REQ-017 spi_miso_oe_o SHALL equal 1 exactly when the state is ACTIVE.

Reset
REQ-018 On rstn_i=0, asynchronously, the block SHALL enter IDLE and clear all synchronisers, shift registers and counters.
REQ-019 During reset SHALL drive: spi_miso_o=MISO_IDLE, spi_miso_oe_o=0, tx_ready_o=1, rx_data_o=0, rx_bytes_valid_o=0, rx_done_o=0, overrun_o=0.
REQ-020 Reset asserted mid-frame SHALL abort the frame with no rx_done_o pulse; the stored transmit word SHALL be lost.

Verification
REQ-021 Load tx 0xA5C3_0000 with 2 bytes valid; master sends 16 bits of MOSI 0x1234 -> MISO bits equal 0xA5C3 then MISO_IDLE; rx_data_o=0x0000_1234; rx_bytes_valid_o=2; one rx_done_o pulse.
REQ-022 Master sends 5 bytes 0x01..0x05 -> rx_data_o=0x0102_0304; rx_bytes_valid_o=4; overrun_o=1.
REQ-023 Master sends 0xFF then 3 bits, then deasserts ss_n -> rx_bytes_valid_o=1; rx_data_o=0x0000_00FF; next frame byte 0x5A is stored intact.
REQ-024 tx_load_i pulsed during ACTIVE -> ignored; MISO is unchanged for the frame.
REQ-025 rx_clear_i asserted in the cycle byte 0x7E completes, with 3 bytes already held -> rx_data_o=0x0000_007E; rx_bytes_valid_o=1.
REQ-026 rstn_i asserted after 4 bits of a frame -> all outputs at reset values; no rx_done_o pulse; a following frame operates normally.
